// File: rtl/t5_seq_if.sv
// t5_seq pipeline-sequencer bundle.
// The master side drives the hazard/bus status; the slave side (the sequencer) returns controls.
interface t5_seq_if;
  logic        iwb_ack;
  logic        dwb_stb;
  logic        dwb_ack;
  logic        xbra;
  logic        dexc;
  logic        dcsr;
  logic        xld;
  logic [4:0]  xrd;
  logic [4:0]  rs1a;
  logic [4:0]  rs2a;
  logic        sena;
  logic        sexe;
  logic        sbub;
  logic        sflush;
  logic        strap;
  logic [2:0]  sstate;
  logic [15:0] sstall;

  modport master (
    output iwb_ack, dwb_stb, dwb_ack, xbra, dexc, dcsr,
    output xld, xrd, rs1a, rs2a,
    input  sena, sexe, sbub, sflush, strap, sstate, sstall
  );

  modport slave (
    input  iwb_ack, dwb_stb, dwb_ack, xbra, dexc, dcsr,
    input  xld, xrd, rs1a, rs2a,
    output sena, sexe, sbub, sflush, strap, sstate, sstall
  );
endinterface

// File: rtl/t5_seq.sv
// t5_seq: pipeline sequencer FSM (stall, bubble, flush, trap, CSR serialise).
// Outputs are registered from the next-state decode, so they track the state reg.
module t5_seq #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CSR_CYC   = 3
) (
  input logic     sclk,
  input logic     srst,
  t5_seq_if.slave bus
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    IWAIT = 3'd1,
    DWAIT = 3'd2,
    HAZ   = 3'd3,
    FLUSH = 3'd4,
    TRAP  = 3'd5,
    CSR   = 3'd6,
    SPARE = 3'd7
  } st_t;

  localparam logic [3:0] FL_LD = 4'(FLUSH_CYC - 1);
  localparam logic [3:0] CS_LD = 4'(CSR_CYC - 1);

  st_t         state, nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        haz;
  logic [4:0]  outs;
  logic [15:0] stall;

  // {sena, sexe, sbub, sflush, strap}
  function automatic logic [4:0] dec(st_t s);
    logic [4:0] o;
    o = 5'b00000;
    unique case (s)
      RUN:     o = 5'b11000;
      IWAIT:   o = 5'b01100;
      DWAIT:   o = 5'b00000;
      HAZ:     o = 5'b01100;
      FLUSH:   o = 5'b11010;
      TRAP:    o = 5'b00001;
      CSR:     o = 5'b01100;
      default: o = 5'b00000;
    endcase
    return o;
  endfunction

  assign haz = bus.xld & (bus.xrd != 5'd0) &
               ((bus.xrd == bus.rs1a) | (bus.xrd == bus.rs2a));

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      RUN: begin
        if (bus.dwb_stb & !bus.dwb_ack) begin
          nxt = DWAIT;
        end else if (bus.xbra) begin
          nxt     = FLUSH;
          cnt_nxt = FL_LD;
        end else if (bus.dexc) begin
          nxt = TRAP;
        end else if (haz) begin
          nxt = HAZ;
        end else if (bus.dcsr) begin
          nxt     = CSR;
          cnt_nxt = CS_LD;
        end else if (!bus.iwb_ack) begin
          nxt = IWAIT;
        end
      end
      IWAIT: begin
        if (bus.xbra) begin
          nxt     = FLUSH;
          cnt_nxt = FL_LD;
        end else if (bus.iwb_ack) begin
          nxt = RUN;
        end
      end
      DWAIT: begin
        if (bus.dwb_ack) begin
          if (bus.xbra) begin
            nxt     = FLUSH;
            cnt_nxt = FL_LD;
          end else begin
            nxt = RUN;
          end
        end
      end
      HAZ: nxt = RUN;
      TRAP: begin
        nxt     = FLUSH;
        cnt_nxt = FL_LD;
      end
      FLUSH: begin
        if (bus.xbra) begin
          cnt_nxt = FL_LD;
        end else if (cnt == 4'd0) begin
          nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CSR: begin
        if (cnt == 4'd0) begin
          nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state <= FLUSH;
      cnt   <= FL_LD;
      outs  <= dec(FLUSH);
      stall <= 16'd0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      outs  <= dec(nxt);
      if (!outs[4] && stall != 16'hFFFF) begin
        stall <= stall + 16'd1;
      end
    end
  end

  assign bus.sena   = outs[4];
  assign bus.sexe   = outs[3];
  assign bus.sbub   = outs[2];
  assign bus.sflush = outs[1];
  assign bus.strap  = outs[0];
  assign bus.sstate = state;
  assign bus.sstall = stall;

endmodule

// File: tb/tb_t5_seq.sv
// tb_t5_seq: vector table plus scoreboard queue for the t5_seq sequencer.
// Expected states come from the state table; outputs come from the Moore decode table.
module tb_t5_seq;

  logic sclk;
  logic srst;

  t5_seq_if bus ();

  t5_seq #(.FLUSH_CYC(2), .CSR_CYC(3)) dut (
    .sclk (sclk),
    .srst (srst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [6:0] f;
    logic [4:0] xrd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] st;
    int         stl;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    int         stl;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  // {sena, sexe, sbub, sflush, strap}
  function automatic logic [4:0] ref_out(logic [2:0] s);
    case (s)
      3'd0:    return 5'b11000;
      3'd1:    return 5'b01100;
      3'd2:    return 5'b00000;
      3'd3:    return 5'b01100;
      3'd4:    return 5'b11010;
      3'd5:    return 5'b00001;
      3'd6:    return 5'b01100;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic vec_t mk(logic [6:0] f, logic [4:0] xrd,
                              logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] st, int stl);
    vec_t v;
    v.f   = f;
    v.xrd = xrd;
    v.rs1 = rs1;
    v.rs2 = rs2;
    v.st  = st;
    v.stl = stl;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(string nm, logic [2:0] st);
    chk({nm, ".state"}, 32'(bus.sstate), 32'(st));
    chk({nm, ".outs"},
        32'({bus.sena, bus.sexe, bus.sbub, bus.sflush, bus.strap}),
        32'(ref_out(st)));
  endtask

  task automatic drive(vec_t v);
    {bus.iwb_ack, bus.dwb_stb, bus.dwb_ack, bus.xbra,
     bus.dexc, bus.dcsr, bus.xld} = v.f;
    bus.xrd  = v.xrd;
    bus.rs1a = v.rs1;
    bus.rs2a = v.rs2;
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t e;
    string nm;
    drive(v);
    e.st  = v.st;
    e.stl = v.stl;
    sb.push_back(e);
    @(posedge sclk);
    #1;
    nm = $sformatf("vec%0d", idx);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk_outs(nm, e.st);
      if (e.stl >= 0) chk({nm, ".sstall"}, 32'(bus.sstall), 32'(e.stl));
    end
  endtask

  localparam logic [6:0] IDLE = 7'b1000000;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    srst   = 1'b0;
    drive(mk(IDLE, 5'd0, 5'd0, 5'd0, 3'd0, -1));

    // reset held across clock edges
    repeat (2) @(posedge sclk);
    #1;
    chk_outs("reset", 3'd4);
    chk("reset.sstall", 32'(bus.sstall), 32'd0);

    // {iwb, dstb, dack, xbra, dexc, dcsr, xld}
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd4, 0));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 0));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 0));
    tab.push_back(mk(7'b1000001, 5'd5, 5'd0, 5'd5, 3'd3, 0));
    tab.push_back(mk(7'b1000001, 5'd5, 5'd0, 5'd5, 3'd0, 1));
    tab.push_back(mk(7'b1000001, 5'd0, 5'd0, 5'd0, 3'd0, 1));
    tab.push_back(mk(7'b1000001, 5'd7, 5'd7, 5'd0, 3'd3, 1));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 2));
    tab.push_back(mk(7'b1101100, 5'd0, 5'd0, 5'd0, 3'd2, 2));
    tab.push_back(mk(7'b1101100, 5'd0, 5'd0, 5'd0, 3'd2, 3));
    tab.push_back(mk(7'b1101100, 5'd0, 5'd0, 5'd0, 3'd2, 4));
    tab.push_back(mk(7'b1101100, 5'd0, 5'd0, 5'd0, 3'd2, 5));
    tab.push_back(mk(7'b1111100, 5'd0, 5'd0, 5'd0, 3'd4, 6));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd4, 6));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 6));
    tab.push_back(mk(7'b1100000, 5'd0, 5'd0, 5'd0, 3'd2, 6));
    tab.push_back(mk(7'b1110000, 5'd0, 5'd0, 5'd0, 3'd0, 7));
    tab.push_back(mk(7'b1111100, 5'd0, 5'd0, 5'd0, 3'd4, 7));
    tab.push_back(mk(7'b1001000, 5'd0, 5'd0, 5'd0, 3'd4, 7));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd4, 7));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 7));
    tab.push_back(mk(7'b1000110, 5'd0, 5'd0, 5'd0, 3'd5, 7));
    tab.push_back(mk(7'b1000100, 5'd0, 5'd0, 5'd0, 3'd4, 8));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd4, 8));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 8));
    tab.push_back(mk(7'b1000010, 5'd0, 5'd0, 5'd0, 3'd6, 8));
    tab.push_back(mk(7'b1000100, 5'd0, 5'd0, 5'd0, 3'd6, 9));
    tab.push_back(mk(7'b1001000, 5'd0, 5'd0, 5'd0, 3'd6, 10));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 11));
    tab.push_back(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd1, 11));
    tab.push_back(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd1, 12));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 13));
    tab.push_back(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd1, 13));
    tab.push_back(mk(7'b0001000, 5'd0, 5'd0, 5'd0, 3'd4, 14));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd4, 14));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 14));
    tab.push_back(mk(7'b1000011, 5'd3, 5'd3, 5'd0, 3'd3, 14));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 15));
    tab.push_back(mk(7'b0000010, 5'd0, 5'd0, 5'd0, 3'd6, 15));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd6, 16));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd6, 17));
    tab.push_back(mk(IDLE,       5'd0, 5'd0, 5'd0, 3'd0, 18));

    @(negedge sclk);
    srst = 1'b1;
    foreach (tab[i]) apply(tab[i], i);

    // long IWAIT stall: counter must pin at all-ones
    drive(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, -1));
    repeat (70000) @(posedge sclk);
    #1;
    chk_outs("sat", 3'd1);
    chk("sat.sstall", 32'(bus.sstall), 32'hFFFF);

    // asynchronous reset away from any clock edge
    #2;
    srst = 1'b0;
    #1;
    chk_outs("async_rst", 3'd4);
    chk("async_rst.sstall", 32'(bus.sstall), 32'd0);
    @(negedge sclk);
    srst = 1'b1;
    apply(mk(IDLE, 5'd0, 5'd0, 5'd0, 3'd4, 0), 100);
    apply(mk(IDLE, 5'd0, 5'd0, 5'd0, 3'd0, 0), 101);
    apply(mk(IDLE, 5'd0, 5'd0, 5'd0, 3'd0, 0), 102);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
